// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the three-digit segment scan controller.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } state_e;

  localparam int unsigned NUM_DIGITS = 3;

  typedef logic [1:0] idx_t;

  localparam idx_t IDX_LAST = idx_t'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] DIGIT_SEL_0 = 3'b001;
  localparam logic [NUM_DIGITS-1:0] DIGIT_SEL_1 = 3'b010;
  localparam logic [NUM_DIGITS-1:0] DIGIT_SEL_2 = 3'b100;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input idx_t idx);
    logic [NUM_DIGITS-1:0] sel;
    case (idx)
      2'd0:    sel = DIGIT_SEL_0;
      2'd1:    sel = DIGIT_SEL_1;
      2'd2:    sel = DIGIT_SEL_2;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_slot_timer.sv
// Per-slot down-counter: flags the last blanking cycle, the cycle before slot end, and slot end.
module slot_timer #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic start_i,
  input  logic run_i,
  output logic blank_done_o,
  output logic slot_pre_o,
  output logic slot_done_o
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntTop   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(SCAN_DIV - BLANK_CYC);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter holds cycles remaining in the slot minus one; reloads itself at slot end.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = CntTop;
    end else if (run_i) begin
      cnt_d = (cnt_q == '0) ? CntTop : cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign blank_done_o = run_i && (BLANK_CYC != 0) && (cnt_q == BlankEnd);
  assign slot_pre_o   = run_i && (cnt_q == CntOne);
  assign slot_done_o  = run_i && (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Three-digit multiplexed 7-segment scanner with per-slot blanking and mode-digit blink.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYC    = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       write_mode,
  input  logic [6:0] seg_mode,
  input  logic [6:0] seg1_action,
  input  logic [6:0] seg2_action,
  output logic [6:0] seg_out,
  output logic [2:0] digit_en,
  output logic       frame_tick
);

  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);
  localparam logic [BlinkW-1:0] BlinkOne  = BlinkW'(1);

  state_e            state_q;
  idx_t              idx_q, idx_next, show_idx;
  logic [6:0]        seg_q, show_seg, pat;
  logic [2:0]        den_q, show_den;
  logic              ft_q, hide;
  logic [BlinkW-1:0] frame_cnt_q, frame_cnt_d;
  logic              blink_q, blink_d;
  logic              blank_done, slot_pre, slot_done;
  logic              tmr_clear, tmr_start, tmr_run;

  assign tmr_clear = !enable;
  assign tmr_start = (state_q == StIdle);
  assign tmr_run   = (state_q != StIdle);

  slot_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .clk_i        (clk),
    .rst_i        (reset),
    .clear_i      (tmr_clear),
    .start_i      (tmr_start),
    .run_i        (tmr_run),
    .blank_done_o (blank_done),
    .slot_pre_o   (slot_pre),
    .slot_done_o  (slot_done)
  );

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (!write_mode) begin
      frame_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (ft_q) begin
      if (frame_cnt_q == BlinkLast) begin
        frame_cnt_d = '0;
        blink_d     = !blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + BlinkOne;
      end
    end
  end

  // Pattern for whichever digit a SHOW entry on this edge would display.
  always_comb begin
    idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 2'd1;
    unique case (state_q)
      StShow:  show_idx = idx_next;
      StBlank: show_idx = idx_q;
      default: show_idx = '0;
    endcase
    case (show_idx)
      2'd0:    pat = seg_mode;
      2'd1:    pat = seg1_action;
      default: pat = seg2_action;
    endcase
    // Uses the next blink phase so a wrap on this edge already affects the new slot.
    hide     = write_mode && !blink_d && (show_idx == '0);
    show_seg = hide ? 7'h00 : pat;
    show_den = hide ? 3'b000 : digit_onehot(show_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      seg_q       <= '0;
      den_q       <= '0;
      ft_q        <= 1'b0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      ft_q        <= 1'b0;
      if (!enable) begin
        state_q <= StIdle;
        idx_q   <= '0;
        seg_q   <= '0;
        den_q   <= '0;
      end else begin
        ft_q <= slot_pre && (idx_q == IDX_LAST);
        unique case (state_q)
          StIdle: begin
            idx_q <= '0;
            if (BLANK_CYC == 0) begin
              state_q <= StShow;
              seg_q   <= show_seg;
              den_q   <= show_den;
            end else begin
              state_q <= StBlank;
            end
          end
          StBlank: begin
            if (blank_done) begin
              state_q <= StShow;
              seg_q   <= show_seg;
              den_q   <= show_den;
            end
          end
          StShow: begin
            if (slot_done) begin
              idx_q <= idx_next;
              if (BLANK_CYC == 0) begin
                seg_q <= show_seg;
                den_q <= show_den;
              end else begin
                state_q <= StBlank;
                seg_q   <= '0;
                den_q   <= '0;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            seg_q   <= '0;
            den_q   <= '0;
          end
        endcase
      end
    end
  end

  assign seg_out    = seg_q;
  assign digit_en   = den_q;
  assign frame_tick = ft_q;

endmodule
